// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: FSM state encoding and default PC width.
package pc_sequencer_pkg;

    localparam int PC_W_DEFAULT = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pc_state_t;

endpackage

// File: rtl/pc_sequencer_next_pc_calc.sv
// Combinational next-PC candidates: sequential and relative-branch targets plus end/out-of-range flags.
module next_pc_calc
    import pc_sequencer_pkg::*;
#(
    parameter int PC_W     = PC_W_DEFAULT,
    parameter int PROG_LEN = 1024
) (
    input  logic [PC_W-1:0] pc_i,
    input  logic [7:0]      offset_i,
    output logic [PC_W-1:0] seq_pc_o,
    output logic            seq_end_o,
    output logic [PC_W-1:0] br_pc_o,
    output logic            br_oor_o
);

    logic [PC_W-1:0] offset_ext;

    // Sign-extend (or truncate) to PC width; the sum then wraps modulo 2**PC_W for free.
    assign offset_ext = PC_W'(signed'(offset_i));

    assign seq_pc_o  = pc_i + PC_W'(1);
    assign seq_end_o = (32'(pc_i) == 32'(PROG_LEN - 1));
    assign br_pc_o   = pc_i + offset_ext;
    assign br_oor_o  = (32'(br_pc_o) >= 32'(PROG_LEN));

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with IDLE/RUN/DONE control. Optional taken-branch counter is
// enabled by defining PC_BRANCH_COUNT_EN; otherwise branch_count is tied to zero.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int PC_W     = PC_W_DEFAULT,
    parameter int PROG_LEN = 1024
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            stall,
    input  logic            halt_instr,
    input  logic            jump_flag,
    input  logic [7:0]      jump_offset,
    output logic [PC_W-1:0] pc,
    output logic            running,
    output logic            done,
    output logic [15:0]     branch_count
);

    pc_state_t       state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] seq_pc;
    logic [PC_W-1:0] br_pc;
    logic            seq_end;
    logic            br_oor;

    next_pc_calc #(
        .PC_W     (PC_W),
        .PROG_LEN (PROG_LEN)
    ) u_next_pc_calc (
        .pc_i      (pc_q),
        .offset_i  (jump_offset),
        .seq_pc_o  (seq_pc),
        .seq_end_o (seq_end),
        .br_pc_o   (br_pc),
        .br_oor_o  (br_oor)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = '0;
                end
            end
            RUN: begin
                if (!stall) begin
                    if (halt_instr) begin
                        state_d = DONE;
                    end else if (jump_flag) begin
                        // An out-of-range target ends the program with pc left at the branch.
                        if (br_oor) state_d = DONE;
                        else        pc_d    = br_pc;
                    end else if (seq_end) begin
                        state_d = DONE;
                    end else begin
                        pc_d = seq_pc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign pc      = pc_q;
    assign running = (state_q == RUN);
    assign done    = (state_q == DONE);

`ifdef PC_BRANCH_COUNT_EN
    logic [15:0] branch_count_q;
    logic        branch_taken;
    logic        count_clear;

    assign branch_taken = (state_q == RUN) && !stall && !halt_instr && jump_flag;
    assign count_clear  = (state_q != RUN) && start;

    always_ff @(posedge clk) begin
        if (reset || count_clear) begin
            branch_count_q <= '0;
        end else if (branch_taken && (branch_count_q != 16'hFFFF)) begin
            branch_count_q <= branch_count_q + 16'd1;
        end
    end

    assign branch_count = branch_count_q;
`else
    assign branch_count = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: two instances (full program and 16-word program) share stimulus,
// a reference model pushes expected outputs to a scoreboard that is drained after each clock.
`timescale 1ns/1ps
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    localparam int PC_W = 10;
`ifdef PC_BRANCH_COUNT_EN
    localparam bit BC_EN = 1'b1;
`else
    localparam bit BC_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset, start, stall, halt_instr, jump_flag;
    logic [7:0]      jump_offset;
    logic [PC_W-1:0] pc_a, pc_b;
    logic            running_a, running_b, done_a, done_b;
    logic [15:0]     bc_a, bc_b;

    always #5 clk = ~clk;

    pc_sequencer dut_a (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stall        (stall),
        .halt_instr   (halt_instr),
        .jump_flag    (jump_flag),
        .jump_offset  (jump_offset),
        .pc           (pc_a),
        .running      (running_a),
        .done         (done_a),
        .branch_count (bc_a)
    );

    pc_sequencer #(.PC_W(PC_W), .PROG_LEN(16)) dut_b (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stall        (stall),
        .halt_instr   (halt_instr),
        .jump_flag    (jump_flag),
        .jump_offset  (jump_offset),
        .pc           (pc_b),
        .running      (running_b),
        .done         (done_b),
        .branch_count (bc_b)
    );

    typedef struct {
        int              unit;
        logic [PC_W-1:0] pc;
        logic            running;
        logic            done;
        logic [15:0]     bc;
    } exp_t;

    exp_t            sb[$];
    pc_state_t       m_state[2];
    logic [PC_W-1:0] m_pc[2];
    logic [15:0]     m_bc[2];
    int              plen[2] = '{1024, 16};
    int              errors = 0;
    int              checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic st, input logic h,
                        input logic j, input logic [7:0] off);
        logic [PC_W-1:0] tgt;
        exp_t            e;
        reset = r; start = s; stall = st; halt_instr = h; jump_flag = j; jump_offset = off;
        for (int u = 0; u < 2; u++) begin
            if (r) begin
                m_state[u] = IDLE; m_pc[u] = '0; m_bc[u] = '0;
            end else begin
                case (m_state[u])
                    RUN: begin
                        if (!st) begin
                            if (h) begin
                                m_state[u] = DONE;
                            end else if (j) begin
                                tgt = m_pc[u] + {{(PC_W-8){off[7]}}, off};
                                if (BC_EN && m_bc[u] != 16'hFFFF) m_bc[u] = m_bc[u] + 16'd1;
                                if (int'(tgt) >= plen[u]) m_state[u] = DONE;
                                else                      m_pc[u]    = tgt;
                            end else if (int'(m_pc[u]) == plen[u] - 1) begin
                                m_state[u] = DONE;
                            end else begin
                                m_pc[u] = m_pc[u] + 1'b1;
                            end
                        end
                    end
                    default: begin
                        if (s) begin
                            m_state[u] = RUN; m_pc[u] = '0; m_bc[u] = '0;
                        end
                    end
                endcase
            end
            e.unit = u; e.pc = m_pc[u]; e.running = (m_state[u] == RUN);
            e.done = (m_state[u] == DONE); e.bc = m_bc[u];
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.unit == 0) begin
                check("a.pc", 32'(pc_a), 32'(e.pc));
                check("a.running", 32'(running_a), 32'(e.running));
                check("a.done", 32'(done_a), 32'(e.done));
                check("a.branch_count", 32'(bc_a), 32'(e.bc));
            end else begin
                check("b.pc", 32'(pc_b), 32'(e.pc));
                check("b.running", 32'(running_b), 32'(e.running));
                check("b.done", 32'(done_b), 32'(e.done));
                check("b.branch_count", 32'(bc_b), 32'(e.bc));
            end
        end
        $display("step r=%0b s=%0b st=%0b h=%0b j=%0b off=%02h | a: pc=%0d run=%0b done=%0b bc=%0d | b: pc=%0d run=%0b done=%0b bc=%0d",
                 r, s, st, h, j, off, pc_a, running_a, done_a, bc_a, pc_b, running_b, done_b, bc_b);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish before 100us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0; stall = 1'b0; halt_instr = 1'b0;
        jump_flag = 1'b0; jump_offset = 8'h00;
        for (int u = 0; u < 2; u++) begin
            m_state[u] = IDLE; m_pc[u] = '0; m_bc[u] = '0;
        end

        // Reset, including reset in the same cycle as start
        step(1, 0, 0, 0, 0, 8'h00);
        step(1, 1, 0, 0, 0, 8'h00);
        check("reset pc", 32'(pc_a), 0);
        check("reset running", 32'(running_a), 0);
        check("reset done", 32'(done_a), 0);
        check("reset branch_count", 32'(bc_a), 0);
        step(0, 0, 0, 0, 0, 8'h00);
        check("idle without start", 32'(running_a), 0);

        // Start and sequential advance
        step(0, 1, 0, 0, 0, 8'h00);
        check("start pc", 32'(pc_a), 0);
        repeat (5) step(0, 0, 0, 0, 0, 8'h00);
        check("seq pc5", 32'(pc_a), 5);
        check("seq running", 32'(running_a), 1);
        repeat (5) step(0, 0, 0, 0, 0, 8'h00);
        check("seq pc10", 32'(pc_a), 10);

        // Backward branch -5
        step(0, 0, 0, 0, 1, 8'hFB);
        check("branch pc5", 32'(pc_a), 5);
        check("branch count1", 32'(bc_a), BC_EN ? 1 : 0);
        step(0, 0, 0, 0, 1, 8'hFE);
        check("branch pc3", 32'(pc_a), 3);

        // Stall ignores jump and halt
        step(0, 0, 1, 0, 1, 8'h04);
        check("stall1 pc", 32'(pc_a), 3);
        step(0, 0, 1, 0, 1, 8'h04);
        check("stall2 pc", 32'(pc_a), 3);
        step(0, 0, 0, 0, 1, 8'h04);
        check("after stall pc", 32'(pc_a), 7);
        step(0, 0, 1, 1, 0, 8'h00);
        check("stalled halt running", 32'(running_a), 1);

        // Halt beats jump, then restart
        step(0, 0, 0, 1, 1, 8'h10);
        check("halt pc", 32'(pc_a), 7);
        check("halt done", 32'(done_a), 1);
        step(0, 1, 0, 0, 0, 8'h00);
        check("restart pc", 32'(pc_a), 0);
        check("restart running", 32'(running_a), 1);
        check("restart branch_count", 32'(bc_a), 0);
        step(0, 1, 0, 0, 0, 8'h00);
        check("start in run ignored", 32'(pc_a), 1);

        // End of program on the 16-word instance
        repeat (14) step(0, 0, 0, 0, 0, 8'h00);
        check("b pc15", 32'(pc_b), 15);
        step(0, 0, 0, 0, 0, 8'h00);
        check("b end pc", 32'(pc_b), 15);
        check("b end done", 32'(done_b), 1);
        check("a past 15", 32'(pc_a), 16);

        // start+stall: stall holds RUN instance, start wins in DONE
        step(0, 1, 1, 0, 0, 8'h00);
        check("a stall with start", 32'(pc_a), 16);
        check("b start wins pc", 32'(pc_b), 0);
        check("b start wins running", 32'(running_b), 1);
        step(0, 0, 0, 0, 0, 8'h00);

        // Wrap below zero lands past PROG_LEN on b; in range on a
        step(0, 0, 0, 0, 1, 8'hFE);
        check("b wrap oor pc", 32'(pc_b), 1);
        check("b wrap oor done", 32'(done_b), 1);
        check("a branch pc15", 32'(pc_a), 15);
        step(0, 0, 0, 0, 1, 8'h80);
        check("a wrap below zero", 32'(pc_a), 911);
        step(0, 0, 0, 0, 1, 8'h7F);
        check("a wrap above max", 32'(pc_a), 14);
        step(0, 0, 0, 0, 1, 8'h1C);
        check("a pc42", 32'(pc_a), 42);

        // Reset mid-run
        step(1, 0, 0, 0, 1, 8'h05);
        check("midrun reset pc", 32'(pc_a), 0);
        check("midrun reset running", 32'(running_a), 0);
        check("midrun reset branch_count", 32'(bc_a), 0);
        step(0, 0, 0, 0, 0, 8'h00);
        check("post reset idle", 32'(running_a), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_W, default 10, program counter width in bits.
REQ-002 Parameter PROG_LEN, default 1024, number of instruction words; PROG_LEN <= 2**PC_W.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  level; request to begin execution from address 0.
REQ-006 stall  input  1  hold PC and state this cycle.
REQ-007 halt_instr  input  1  decoded halt instruction at current PC.
REQ-008 jump_flag  input  1  taken-branch flag from the ALU.
REQ-009 jump_offset  input  8  ALU result, signed two's-complement relative branch offset.
REQ-010 pc  output  PC_W  current instruction address to instruction memory.
REQ-011 running  output  1  high while in RUN state.
REQ-012 done  output  1  high while in DONE state.
REQ-013 branch_count  output  16  count of taken branches (see Configuration).

Function
REQ-014 FSM states: IDLE, RUN, DONE; outputs are registered or decoded from registered state only.
REQ-015 IDLE: pc=0, running=0, done=0; start=1 -> RUN next cycle with pc=0.
REQ-016 RUN, stall=1: pc, state, branch_count unchanged; halt_instr and jump_flag ignored that cycle.
REQ-017 RUN, stall=0, halt_instr=1: -> DONE next cycle, pc unchanged; halt has priority over jump_flag.
REQ-018 RUN, stall=0, halt_instr=0, jump_flag=1: pc <= pc + sign_extend(jump_offset) modulo 2**PC_W.
REQ-019 RUN, stall=0, halt_instr=0, jump_flag=0: pc <= pc + 1.
REQ-020 RUN, sequential advance with pc == PROG_LEN-1: -> DONE, pc unchanged (end-of-program).
REQ-021 Branch target wrap: negative offsets below 0 and overflow above 2**PC_W-1 wrap modulo 2**PC_W; no error flagged.
REQ-022 Branch to target >= PROG_LEN: -> DONE next cycle, pc holds pre-branch value.
REQ-023 DONE: done=1, running=0, pc held; start=1 -> RUN next cycle with pc=0; branch_count cleared on this restart.
REQ-024 start while RUN ignored; start and stall together in IDLE/DONE: start wins (stall applies only in RUN).
REQ-025 Latency: every PC update visible one cycle after the qualifying inputs are sampled.
REQ-026 jump_flag and jump_offset are don't-care outside RUN.

Reset
REQ-027 reset=1 at a rising edge: state=IDLE, pc=0, running=0, done=0, branch_count=0.
REQ-028 reset takes priority over all inputs, including mid-RUN and the cycle of start.
REQ-029 After reset deasserts, block remains in IDLE until start=1 is sampled.

Configuration
REQ-030 Macro PC_BRANCH_COUNT_EN: when defined, branch_count increments by 1 on every taken branch per REQ-018, saturating at 16'hFFFF.
REQ-031 Without PC_BRANCH_COUNT_EN, branch_count is constant 0 and no counter register is synthesized; the port remains present.

Structure
REQ-032 Shared package definitions holds pc_state_t enum (IDLE, RUN, DONE) and default PC_W constant.
REQ-033 One combinational sub-module, next_pc_calc, computes sequential and branch candidates plus out-of-range flags; FSM and registers stay in pc_sequencer.

Verification
REQ-034 reset, start=1 one cycle, 5 cycles no jump -> pc 0,1,2,3,4,5; running=1.
REQ-035 pc=10, jump_flag=1, jump_offset=8'hFB -> pc=5 next cycle; branch_count=1 (macro on), 0 (macro off).
REQ-036 pc=3, stall=1 with jump_flag=1 for 2 cycles, then stall=0 -> pc 3,3, then 3+offset.
REQ-037 halt_instr=1 and jump_flag=1 same cycle at pc=7 -> DONE, pc=7, done=1; start=1 -> pc=0, running=1.
REQ-038 PROG_LEN=16, pc=15 sequential -> DONE, pc=15; pc=1, offset=8'hFE -> wraps to 2**PC_W-1 >= PROG_LEN -> DONE, pc=1.
REQ-039 reset=1 mid-RUN at pc=42 -> next cycle pc=0, IDLE, running=0, branch_count=0.
